vec_cache_wr_cmd_arb: RTL and testbench

Per-lane write-command arbiter for the sram_group loop-back path. In each of NUM_LANE lanes, a west requester (local write path) and an east requester (east WDB) compete for the single west write-command output. The block replaces the "never simultaneously valid" rule with round-robin arbitration, per-source backpressure and a registered output stage. It also provides a saturating conflict counter per lane for performance visibility.

---
 rtl/vec_cache_wr_cmd_arb.sv | 127 ++++++++++++
 tb/tb_vec_cache_wr_cmd_arb.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_cache_wr_cmd_arb.sv
// Per-lane west/east write-command arbiter with round-robin tie-break,
// a one-deep registered output stage and a saturating conflict counter.

module vec_cache_wr_cmd_arb_lane #(
    parameter int PLD_W = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             west_vld,
    input  logic [PLD_W-1:0] west_pld,
    output logic             west_rdy,
    input  logic             east_vld,
    input  logic [PLD_W-1:0] east_pld,
    output logic             east_rdy,
    output logic             out_vld,
    output logic [PLD_W-1:0] out_pld,
    output logic             out_src,
    input  logic             out_rdy,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt
);
    typedef struct packed {
        logic             src;
        logic [PLD_W-1:0] pld;
    } cmd_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    cmd_t             held_q;
    cmd_t             win_cmd;
    logic             full_q;
    logic             rr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             contend;
    logic             win_east;
    logic             can_load;
    logic             load;

    // Grant depends only on valids, rr and output occupancy; payload is muxed
    // separately so no pld ever reaches a ready.
    always_comb begin
        contend     = west_vld & east_vld;
        win_east    = east_vld & (~west_vld | rr_q);
        can_load    = ~full_q | out_rdy;
        load        = rst_n & can_load & (west_vld | east_vld);
        west_rdy    = load & ~win_east;
        east_rdy    = load & win_east;
        win_cmd.src = win_east;
        win_cmd.pld = win_east ? east_pld : west_pld;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            held_q <= '0;
            rr_q   <= 1'b0;
        end else begin
            if (load) begin
                full_q <= 1'b1;
                held_q <= win_cmd;
                if (contend) rr_q <= ~win_east;
            end else if (out_rdy) begin
                full_q <= 1'b0;
            end
        end
    end

    // Counts contended cycles whether or not a grant happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (contend && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    assign out_vld = full_q;
    assign out_pld = held_q.pld;
    assign out_src = held_q.src;
    assign cnt     = cnt_q;
endmodule

module vec_cache_wr_cmd_arb #(
    parameter int NUM_LANE = 8,
    parameter int PLD_W    = 64,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_LANE-1:0]       west_cmd_vld,
    input  logic [NUM_LANE*PLD_W-1:0] west_cmd_pld,
    output logic [NUM_LANE-1:0]       west_cmd_rdy,
    input  logic [NUM_LANE-1:0]       east_cmd_vld,
    input  logic [NUM_LANE*PLD_W-1:0] east_cmd_pld,
    output logic [NUM_LANE-1:0]       east_cmd_rdy,
    output logic [NUM_LANE-1:0]       out_cmd_vld,
    output logic [NUM_LANE*PLD_W-1:0] out_cmd_pld,
    output logic [NUM_LANE-1:0]       out_cmd_src,
    input  logic [NUM_LANE-1:0]       out_cmd_rdy,
    input  logic                      cnt_clr,
    output logic [NUM_LANE*CNT_W-1:0] conflict_cnt
);
    for (genvar i = 0; i < NUM_LANE; i++) begin : g_lane
        vec_cache_wr_cmd_arb_lane #(
            .PLD_W (PLD_W),
            .CNT_W (CNT_W)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .west_vld (west_cmd_vld[i]),
            .west_pld (west_cmd_pld[i*PLD_W +: PLD_W]),
            .west_rdy (west_cmd_rdy[i]),
            .east_vld (east_cmd_vld[i]),
            .east_pld (east_cmd_pld[i*PLD_W +: PLD_W]),
            .east_rdy (east_cmd_rdy[i]),
            .out_vld  (out_cmd_vld[i]),
            .out_pld  (out_cmd_pld[i*PLD_W +: PLD_W]),
            .out_src  (out_cmd_src[i]),
            .out_rdy  (out_cmd_rdy[i]),
            .cnt_clr  (cnt_clr),
            .cnt      (conflict_cnt[i*CNT_W +: CNT_W])
        );
    end
endmodule

// File: tb/tb_vec_cache_wr_cmd_arb.sv
// Scoreboard bench for vec_cache_wr_cmd_arb: a per-lane reference model
// predicts readies and queues accepted commands; a monitor drains them.

module tb_vec_cache_wr_cmd_arb;
    localparam int NL   = 8;
    localparam int PW   = 64;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NL-1:0]    west_cmd_vld, west_cmd_rdy, east_cmd_vld, east_cmd_rdy;
    logic [NL-1:0]    out_cmd_vld, out_cmd_src, out_cmd_rdy;
    logic [NL*PW-1:0] west_cmd_pld, east_cmd_pld, out_cmd_pld;
    logic             cnt_clr;
    logic [NL*CW-1:0] conflict_cnt;

    typedef struct packed {
        logic          src;
        logic [PW-1:0] pld;
    } cmd_t;

    cmd_t exp_q[NL][$];
    bit   m_rr[NL];
    int   m_cnt[NL];
    bit   acc_w[NL];
    bit   acc_e[NL];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    vec_cache_wr_cmd_arb #(.NUM_LANE(NL), .PLD_W(PW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .west_cmd_vld (west_cmd_vld),
        .west_cmd_pld (west_cmd_pld),
        .west_cmd_rdy (west_cmd_rdy),
        .east_cmd_vld (east_cmd_vld),
        .east_cmd_pld (east_cmd_pld),
        .east_cmd_rdy (east_cmd_rdy),
        .out_cmd_vld  (out_cmd_vld),
        .out_cmd_pld  (out_cmd_pld),
        .out_cmd_src  (out_cmd_src),
        .out_cmd_rdy  (out_cmd_rdy),
        .cnt_clr      (cnt_clr),
        .conflict_cnt (conflict_cnt)
    );

    task automatic chk(input string name, input int lane, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane %0d: got %0h expected %0h", name, lane, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            exp_q[i].delete();
            m_rr[i]  = 1'b0;
            m_cnt[i] = 0;
            acc_w[i] = 1'b1;
            acc_e[i] = 1'b1;
        end
    endtask

    // Called at posedge+1 with inputs applied; predicts this edge, returns at next posedge+1.
    task automatic cycle();
        #3;
        for (int i = 0; i < NL; i++) begin
            bit w, e, cl, eg, ew, ee;
            w  = west_cmd_vld[i];
            e  = east_cmd_vld[i];
            cl = (exp_q[i].size() == 0) || out_cmd_rdy[i];
            eg = e && (!w || m_rr[i]);
            ew = cl && w && !eg;
            ee = cl && eg;
            chk("west_rdy", i, 64'(west_cmd_rdy[i]), 64'(ew));
            chk("east_rdy", i, 64'(east_cmd_rdy[i]), 64'(ee));
            if (ew) exp_q[i].push_back({1'b0, west_cmd_pld[i*PW +: PW]});
            if (ee) exp_q[i].push_back({1'b1, east_cmd_pld[i*PW +: PW]});
            if (w && e && cl) m_rr[i] = !eg;
            if (cnt_clr) m_cnt[i] = 0;
            else if (w && e && m_cnt[i] < CMAX) m_cnt[i]++;
            acc_w[i] = ew;
            acc_e[i] = ee;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        west_cmd_vld = '0;
        east_cmd_vld = '0;
        west_cmd_pld = '0;
        east_cmd_pld = '0;
        out_cmd_rdy  = '1;
        cnt_clr      = 1'b0;
    endtask

    // Monitor: compares the held command whenever the DUT presents one.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (mon_en) begin
                for (int i = 0; i < NL; i++) begin
                    chk("out_vld", i, 64'(out_cmd_vld[i]), 64'(exp_q[i].size() > 0));
                    if (out_cmd_vld[i] && exp_q[i].size() > 0) begin
                        chk("out_pld", i, out_cmd_pld[i*PW +: PW], exp_q[i][0].pld);
                        chk("out_src", i, 64'(out_cmd_src[i]), 64'(exp_q[i][0].src));
                        if (out_cmd_rdy[i]) void'(exp_q[i].pop_front());
                    end
                    chk("conflict_cnt", i, 64'(conflict_cnt[i*CW +: CW]), 64'(m_cnt[i]));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        idle_inputs();
        west_cmd_vld = '1;
        east_cmd_vld = '1;
        #1;
        chk("rst_west_rdy", 0, 64'(west_cmd_rdy), 64'(0));
        chk("rst_east_rdy", 0, 64'(east_cmd_rdy), 64'(0));
        chk("rst_out_vld", 0, 64'(out_cmd_vld), 64'(0));
        chk("rst_out_src", 0, 64'(out_cmd_src), 64'(0));
        chk("rst_out_pld0", 0, out_cmd_pld[63:0], 64'(0));
        chk("rst_cnt", 0, 64'(conflict_cnt[31:0]), 64'(0));
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        cycle();

        // Single west command on lane 0.
        west_cmd_vld[0]     = 1'b1;
        west_cmd_pld[63:0]  = 64'h11;
        cycle();
        west_cmd_vld[0] = 1'b0;
        chk("dir_l0_vld", 0, 64'(out_cmd_vld[0]), 64'(1));
        chk("dir_l0_pld", 0, out_cmd_pld[63:0], 64'h11);
        chk("dir_l0_src", 0, 64'(out_cmd_src[0]), 64'(0));
        cycle();
        chk("dir_l0_empty", 0, 64'(out_cmd_vld[0]), 64'(0));

        // Lane 3 continuous contention alternates west/east.
        west_cmd_vld[3] = 1'b1;
        east_cmd_vld[3] = 1'b1;
        west_cmd_pld[3*PW +: PW] = 64'hA;
        east_cmd_pld[3*PW +: PW] = 64'hB;
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("dir_rr_src", 3, 64'(out_cmd_src[3]), 64'(k % 2));
            chk("dir_rr_pld", 3, out_cmd_pld[3*PW +: PW], (k % 2) ? 64'hB : 64'hA);
        end
        chk("dir_cnt6", 3, 64'(conflict_cnt[3*CW +: CW]), 64'(6));
        west_cmd_vld[3] = 1'b0;
        east_cmd_vld[3] = 1'b0;
        cycle();

        // Lane 5 backpressure, then drain-and-load in one cycle.
        east_cmd_vld[5] = 1'b1;
        east_cmd_pld[5*PW +: PW] = 64'h51;
        out_cmd_rdy[5] = 1'b0;
        cycle();
        east_cmd_pld[5*PW +: PW] = 64'h52;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("dir_hold_vld", 5, 64'(out_cmd_vld[5]), 64'(1));
            chk("dir_hold_pld", 5, out_cmd_pld[5*PW +: PW], 64'h51);
        end
        out_cmd_rdy[5] = 1'b1;
        cycle();
        east_cmd_vld[5] = 1'b0;
        chk("dir_b2b_vld", 5, 64'(out_cmd_vld[5]), 64'(1));
        chk("dir_b2b_pld", 5, out_cmd_pld[5*PW +: PW], 64'h52);
        cycle();

        // Random traffic on all lanes; sources hold until accepted.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NL; i++) begin
                if (!(west_cmd_vld[i] && !acc_w[i])) begin
                    west_cmd_vld[i] = 1'($urandom_range(0, 1));
                    west_cmd_pld[i*PW +: PW] = {$urandom, $urandom};
                end
                if (!(east_cmd_vld[i] && !acc_e[i])) begin
                    east_cmd_vld[i] = 1'($urandom_range(0, 1));
                    east_cmd_pld[i*PW +: PW] = {$urandom, $urandom};
                end
                out_cmd_rdy[i] = ($urandom_range(0, 3) != 0);
            end
            cnt_clr = ($urandom_range(0, 31) == 0);
            cycle();
        end
        idle_inputs();
        cycle();
        cycle();
        for (int i = 0; i < NL; i++) chk("drained", i, 64'(exp_q[i].size()), 64'(0));

        // Counter saturation and clear priority on lane 1.
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        west_cmd_vld[1] = 1'b1;
        east_cmd_vld[1] = 1'b1;
        for (int k = 0; k < 20; k++) cycle();
        chk("dir_sat", 1, 64'(conflict_cnt[1*CW +: CW]), 64'(15));
        cnt_clr = 1'b1;
        cycle();
        chk("dir_clr", 1, 64'(conflict_cnt[1*CW +: CW]), 64'(0));
        cnt_clr = 1'b0;
        cycle();
        chk("dir_after_clr", 1, 64'(conflict_cnt[1*CW +: CW]), 64'(1));
        idle_inputs();
        cycle();
        cycle();

        // Reset while lane 2 is FULL with rr pointing east.
        west_cmd_vld[2] = 1'b1;
        east_cmd_vld[2] = 1'b1;
        west_cmd_pld[2*PW +: PW] = 64'h2A;
        east_cmd_pld[2*PW +: PW] = 64'h2B;
        for (int k = 0; k < 4 && !(m_rr[2] && exp_q[2].size() > 0); k++) cycle();
        chk("dir_pre_rst_vld", 2, 64'(out_cmd_vld[2]), 64'(1));
        #2;
        rst_n  = 1'b0;
        mon_en = 1'b0;
        model_reset();
        #1;
        chk("dir_async_rst", 2, 64'(out_cmd_vld[2]), 64'(0));
        chk("dir_rst_rdy", 2, 64'(west_cmd_rdy[2]), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        cycle();
        chk("dir_post_rst_src", 2, 64'(out_cmd_src[2]), 64'(0));
        chk("dir_post_rst_pld", 2, out_cmd_pld[2*PW +: PW], 64'h2A);
        idle_inputs();
        cycle();
        cycle();
        for (int i = 0; i < NL; i++) chk("final_drain", i, 64'(exp_q[i].size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
